// File: rtl/dma_pkg.sv
// Shared constants for the byte DMA read controller: FSM state encoding and
// default address/length widths.
package dma_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_LEN_W  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dma_out_buf.sv
// Two-entry byte FIFO between the memory read port and the downstream
// handshake. The read-issue rule upstream guarantees it is never pushed when full.
module dma_out_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [1:0] count,
  output logic [7:0] head
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;

  // NOTE: storage is deliberately not reset; the pointers and count decide
  // which entries are visible, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/byte_dma_rd_ctrl.sv
// Byte-wide DMA read engine: streams length bytes from base_addr out of a
// one-cycle-latency memory into a valid/ready port through a 2-entry buffer.
module byte_dma_rd_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bytes_sent,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              m_valid,
  output logic [7:0]        m_data,
  input  logic              m_ready
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic              rd_pending;
  logic [1:0]        buf_count;
  logic [2:0]        occupancy;
  logic              pop;
  logic              flush;
  logic              last_issue;
  logic              drain_empty;

  assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);
  assign m_valid = (buf_count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign flush   = abort && busy;

  // Entries already held or in flight, minus the one leaving this cycle.
  assign occupancy  = {1'b0, buf_count} + {2'b00, rd_pending} - {2'b00, pop};
  assign mem_rd_en  = (state == ST_RUN) && (occupancy < 3'd2);
  assign mem_addr   = base_q + ADDR_W'(issued);
  assign last_issue = mem_rd_en && ((issued + LEN_W'(1)) == len_q);
  assign drain_empty = !rd_pending &&
                       ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop));

  // NOTE: state_nxt gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (abort) state_nxt = ST_IDLE;
                else if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (abort) state_nxt = ST_IDLE;
                else if (drain_empty) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued     <= '0;
      bytes_sent <= '0;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pending <= mem_rd_en && !flush;
      if (state == ST_IDLE && start) begin
        base_q     <= base_addr;
        len_q      <= length;
        issued     <= '0;
        bytes_sent <= '0;
      end else begin
        if (mem_rd_en) issued     <= issued + LEN_W'(1);
        if (pop)       bytes_sent <= bytes_sent + LEN_W'(1);
      end
    end
  end

  dma_out_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (rd_pending),
    .push_data (mem_rd_data),
    .pop       (pop),
    .count     (buf_count),
    .head      (m_data)
  );

endmodule

// File: tb/tb_byte_dma_rd_ctrl.sv
// Self-checking bench for byte_dma_rd_ctrl: table of transfers plus
// hand-written abort and mid-transfer reset sequences, with a byte scoreboard.
module tb_byte_dma_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] bytes_sent;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_addr[$];
  logic [7:0]  exp_data[$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [3:0]  pat;
    int          poke;
    int          exp_done;
    int          exp_first_v;
    int          exp_sent;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  byte_dma_rd_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .bytes_sent  (bytes_sent),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory model with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_byte(mem_addr);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard monitor: addresses, delivered bytes, stability under stall.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (exp_addr.size() == 0) check("spurious_read", 1, 0);
        else check("mem_addr", int'(mem_addr), int'(exp_addr.pop_front()));
      end
      if (m_valid && m_ready) begin
        if (exp_data.size() == 0) check("spurious_byte", 1, 0);
        else check("m_data", int'(m_data), int'(exp_data.pop_front()));
      end
      if (prev_stall && m_valid) check("stall_stable", int'(m_data), int'(prev_data));
      if (m_valid) check("buf_le2", int'(dut.u_buf.count > 2'd2), 0);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic run_xfer(input logic [15:0] b, input logic [15:0] l, input logic [3:0] pat,
                          input int poke, output int done_cyc, output int first_rd,
                          output int first_v, output int last_hs, output int saw_busy,
                          output int sent);
    int c;
    done_cyc = -1; first_rd = -1; first_v = -1; last_hs = -1; saw_busy = 0; sent = -1;
    for (int i = 0; i < int'(l); i++) begin
      exp_addr.push_back(b + 16'(i));
      exp_data.push_back(mem_byte(b + 16'(i)));
    end
    base_addr = b; length = l; start = 1'b1; m_ready = pat[0];
    c = 0;
    while (done_cyc < 0 && c < 300) begin
      @(negedge clk);
      if (mem_rd_en && first_rd < 0) first_rd = c;
      if (m_valid && first_v < 0) first_v = c;
      if (m_valid && m_ready) last_hs = c;
      if (busy) saw_busy = 1;
      if (done) begin done_cyc = c; sent = int'(bytes_sent); end
      @(posedge clk); #1;
      start = 1'b0;
      c++;
      m_ready = pat[c % 4];
      if (c == poke) begin
        start = 1'b1; base_addr = 16'h9999; length = 16'd2;
      end
    end
    if (done_cyc < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int dc, fr, fv, lh, sb, st, hs, c;

    vecs[0] = '{16'h0010, 16'd4, 4'b1111, -1, 7, 3, 4};
    vecs[1] = '{16'h1234, 16'd0, 4'b1111, -1, 1, -1, 0};
    vecs[2] = '{16'hFFFE, 16'd4, 4'b1111, -1, 7, 3, 4};
    vecs[3] = '{16'h0040, 16'd8, 4'b1001, -1, -1, 3, 8};
    vecs[4] = '{16'h0200, 16'd6, 4'b1111, 2, 9, 3, 6};
    vecs[5] = '{16'h7FFF, 16'd1, 4'b1111, -1, 4, 3, 1};
    vecs[6] = '{16'h0080, 16'd5, 4'b0101, -1, -1, 3, 5};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    base_addr = '0; length = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_mem_rd_en", int'(mem_rd_en), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_bytes_sent", int'(bytes_sent), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].base, vecs[i].len, vecs[i].pat, vecs[i].poke, dc, fr, fv, lh, sb, st);
      if (vecs[i].exp_done >= 0) check($sformatf("v%0d_done_cycle", i), dc, vecs[i].exp_done);
      else check($sformatf("v%0d_done_after_last_hs", i), dc, lh + 1);
      check($sformatf("v%0d_first_rd", i), fr, (vecs[i].len != 0) ? 1 : -1);
      check($sformatf("v%0d_first_valid", i), fv, vecs[i].exp_first_v);
      check($sformatf("v%0d_busy_seen", i), sb, (vecs[i].len != 0) ? 1 : 0);
      check($sformatf("v%0d_bytes_sent", i), st, vecs[i].exp_sent);
      check($sformatf("v%0d_data_drained", i), exp_data.size(), 0);
    end

    // Abort after five handshakes.
    for (int i = 0; i < 16; i++) begin
      exp_addr.push_back(16'h0100 + 16'(i));
      exp_data.push_back(mem_byte(16'h0100 + 16'(i)));
    end
    base_addr = 16'h0100; length = 16'd16; start = 1'b1; m_ready = 1'b1;
    hs = 0; c = 0;
    while (hs < 5 && c < 100) begin
      @(negedge clk);
      if (m_valid && m_ready) hs++;
      @(posedge clk); #1;
      start = 1'b0; c++;
    end
    check("abort_hs_reached", hs, 5);
    abort = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_addr.delete(); exp_data.delete();
    @(negedge clk);
    check("abort_m_valid", int'(m_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_bytes_sent", int'(bytes_sent), 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", int'(done || m_valid || busy), 0);
    end
    @(posedge clk); #1;
    run_xfer(16'h0500, 16'd3, 4'b1111, -1, dc, fr, fv, lh, sb, st);
    check("post_abort_done_cycle", dc, 6);
    check("post_abort_bytes_sent", st, 3);

    // Reset in the middle of a transfer.
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(16'h0300 + 16'(i));
      exp_data.push_back(mem_byte(16'h0300 + 16'(i)));
    end
    base_addr = 16'h0300; length = 16'd8; start = 1'b1; m_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("midrst_was_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_mem_rd_en", int'(mem_rd_en), 0);
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_bytes_sent", int'(bytes_sent), 0);
    check("midrst_mem_addr", int'(mem_addr), 0);
    exp_addr.delete(); exp_data.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_quiet", int'(done || m_valid || mem_rd_en), 0);
    end
    @(posedge clk); #1;
    run_xfer(16'h0600, 16'd2, 4'b1111, -1, dc, fr, fv, lh, sb, st);
    check("post_rst_done_cycle", dc, 5);
    check("post_rst_bytes_sent", st, 2);
    check("final_addr_q_empty", exp_addr.size(), 0);
    check("final_data_q_empty", exp_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/byte_dma_rd_ctrl.md
BYTE_DMA_RD_CTRL -- requirements
Module: byte_dma_rd_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, memory byte-address width; LEN_W, default 16, transfer-length width.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  start request; sampled in IDLE only.
REQ-005 base_addr  input  ADDR_W  first byte address; captured with start.
REQ-006 length  input  LEN_W  byte count; captured with start.
REQ-007 abort  input  1  cancel the active transfer.
REQ-008 busy  output  1  high in RUN or DRAIN.
REQ-009 done  output  1  one-cycle pulse on normal completion.
REQ-010 bytes_sent  output  LEN_W  downstream handshakes in the current or last transfer.
REQ-011 mem_rd_en  output  1  memory read strobe.
REQ-012 mem_addr  output  ADDR_W  read address; valid while mem_rd_en is high.
REQ-013 mem_rd_data  input  8  read data; valid exactly one cycle after mem_rd_en.
REQ-014 m_valid  output  1  downstream byte valid.
REQ-015 m_data  output  8  downstream byte.
REQ-016 m_ready  input  1  downstream ready.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN SHALL occur on start with length!=0; base_addr and length are latched, and bytes_sent and the issue counter are cleared.
REQ-019 IDLE->DONE SHALL occur on start with length==0; no memory read is issued.
REQ-020 RUN->DRAIN SHALL occur in the cycle the length-th read is issued.
REQ-021 DRAIN->DONE SHALL occur when no read is pending, the buffer is empty, and the last byte has been accepted.
REQ-022 DONE->IDLE SHALL occur unconditionally after one cycle; done=1 only in DONE.
REQ-023 The block SHALL hold a 2-entry output buffer; m_valid=buffer non-empty; m_data=head entry.
REQ-024 The read-issue rule SHALL be: mem_rd_en=1 in RUN iff (buf_count + rd_pending - pop) < 2.
REQ-025 In REQ-024, pop = m_valid & m_ready, and rd_pending = mem_rd_en registered.
REQ-026 Data capture SHALL be: if rd_pending=1, mem_rd_data is written into the buffer at the clock edge of that cycle.
REQ-027 mem_addr SHALL be base_addr + issued count, wrapping modulo 2^ADDR_W.
REQ-028 Latency: start high in cycle 0 -> first mem_rd_en in cycle 1 -> m_valid with byte 0 in cycle 3.
REQ-029 Throughput: with m_ready held at 1, one byte SHALL be sent per cycle.
REQ-030 With m_ready held at 1, done SHALL be high in cycle 3+length.
REQ-031 Backpressure: while m_valid=1 and m_ready=0, m_data SHALL be held stable.
REQ-032 Backpressure: the buffer SHALL never overflow, and no byte is dropped or duplicated.
REQ-033 bytes_sent SHALL increment per handshake and hold its value after DONE until the next accepted start.
REQ-034 start SHALL be ignored outside IDLE, and the latched parameters stay unchanged.
REQ-035 abort in RUN or DRAIN SHALL give IDLE next cycle: buffer flushed, rd_pending cleared, returning read data discarded.
REQ-036 After abort, done SHALL NOT be asserted, m_valid=0 and busy=0 from the next cycle, and bytes_sent holds.
REQ-037 abort SHALL be ignored in IDLE and DONE; with start and abort both high in IDLE, start is accepted.
REQ-038 busy SHALL be 0 in IDLE and DONE.

Reset
REQ-039 On rst_n=0 at a clock edge: state=IDLE; busy, done, mem_rd_en, m_valid, rd_pending and buffer count=0; bytes_sent=0; mem_addr=0.
REQ-040 Reset mid-transfer SHALL abandon the transfer without a done pulse; data returning after reset is discarded.
REQ-041 Buffer storage contents need not be reset.

Structure
REQ-042 Shared package dma_pkg SHALL hold: state encoding constants (IDLE, RUN, DRAIN, DONE) and ADDR_W/LEN_W defaults.
REQ-043 One sub-module SHALL exist: dma_out_buf, a 2-entry byte buffer with synchronous active-low reset, flush input, push/pop and count output.
REQ-044 The FSM, counters and address generation SHALL reside in byte_dma_rd_ctrl.

Verification
REQ-045 Basic: base=0x0010, len=4, m_ready=1 -> mem_addr 0x10..0x13 in cycles 1-4, m_data=mem[0x10..0x13] in cycles 3-6, done in cycle 7, bytes_sent=4.
REQ-046 Backpressure: len=8, m_ready toggling 1,0,0,1,... -> 8 bytes in order, no duplicates, buffer never exceeds 2, done after the 8th handshake.
REQ-047 Zero length: start with len=0 -> no mem_rd_en, done in cycle 1, busy stays 0.
REQ-048 Wrap: base=0xFFFE, len=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-049 Abort: len=16, abort after 5 handshakes -> IDLE next cycle, m_valid=0, no done, bytes_sent=5; a new start then runs correctly.
REQ-050 Start while busy and mid-transfer reset: start ignored with transfer unchanged; rst_n=0 in RUN -> all outputs at reset values next cycle.
